// File: rtl/ring_token_arbiter.sv
// Ring-token round-robin arbiter: one grant at a time, tenure capped at MAX_HOLD cycles,
// priority pointer rotates to the slot after each released winner.
module ring_token_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [N-1:0] token,
    output logic         busy,
    output logic         expire
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, next_state;
    logic [CW-1:0] hold_cnt, hold_next;
    logic [N-1:0]  gnt_next, token_next;
    logic [N-1:0]  upper_req, search, winner;
    logic          expire_next, held, tenure_up, release_now;

    // Requests at or above the token position win first; otherwise wrap to the lowest set bit.
    assign upper_req   = req & ~(token - ONE);
    assign search      = (|upper_req) ? upper_req : req;
    assign winner      = search & (~search + ONE);

    assign held        = |(req & gnt);
    assign tenure_up   = (hold_cnt == CW'(MAX_HOLD));
    assign release_now = !held || tenure_up;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req)       next_state = GRANT;
            GRANT:   if (release_now) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt_next    = gnt;
        token_next  = token;
        hold_next   = hold_cnt;
        expire_next = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_next  = winner;
                    hold_next = CW'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_next    = '0;
                    token_next  = {gnt[N-2:0], gnt[N-1]};
                    hold_next   = '0;
                    // A winner that drops req on the limit edge released voluntarily.
                    expire_next = held && tenure_up;
                end else begin
                    hold_next = hold_cnt + CW'(1);
                end
            end
            default: begin
                gnt_next  = '0;
                hold_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt      <= '0;
            token    <= ONE;
            hold_cnt <= '0;
            expire   <= 1'b0;
        end else begin
            gnt      <= gnt_next;
            token    <= token_next;
            hold_cnt <= hold_next;
            expire   <= expire_next;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: doc/ring_token_arbiter.md
RING_TOKEN_ARBITER -- requirements
Module: ring_token_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum grant tenure in cycles (MAX_HOLD >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req, input, N bits: request per requester, level-sensitive, held high for as long as access is wanted.
REQ-006 The block SHALL have port gnt, output, N bits: registered grant, one-hot or zero.
REQ-007 The block SHALL have port token, output, N bits: registered one-hot ring priority pointer.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in state GRANT.
REQ-009 The block SHALL have port expire, output, 1 bit: registered one-cycle pulse when a grant is revoked by tenure limit.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 token SHALL always be one-hot; it rotates as a ring counter (bit i to bit i+1, bit N-1 wraps to bit 0) and never holds 0 or multiple ones.
REQ-012 In IDLE with req != 0, the winner SHALL be the first set req bit found searching from the token position upward with wrap (token position included).
REQ-013 On the edge where IDLE sees a winner, the block SHALL load gnt = one-hot(winner), enter GRANT, and clear the hold counter to 1: one-cycle req-to-gnt latency.
REQ-014 In IDLE with req == 0, gnt SHALL stay 0, token SHALL stay unchanged, and the FSM SHALL stay in IDLE.
REQ-015 In GRANT, gnt SHALL stay constant; req bits of non-winners SHALL be ignored.
REQ-016 In GRANT, the hold counter SHALL count cycles with gnt high and be sized to represent MAX_HOLD.
REQ-017 The block SHALL release the grant at the edge where req[winner] is sampled low, or where the hold counter equals MAX_HOLD; gnt is therefore high at most MAX_HOLD consecutive cycles.
REQ-018 On release, the block SHALL clear gnt to 0, set token to the winner rotated by one (the position after the winner), and return to IDLE.
REQ-019 There SHALL be exactly one gnt-low cycle between consecutive grants.
REQ-020 expire SHALL pulse high for exactly one cycle, coincident with the first gnt-low cycle, only when release was caused by the tenure limit while req[winner] was still high.
REQ-021 If req[winner] drops on the same edge that the counter reaches MAX_HOLD, the release SHALL count as voluntary: expire = 0.
REQ-022 A requester that is released and still requesting SHALL get lowest priority in the next arbitration, because of the token rotation.
REQ-023 busy SHALL equal (state == GRANT) and SHALL be registered consistently with gnt, so that busy == |gnt at every cycle.
REQ-024 The block SHALL contain no combinational path from req to any output.

Reset
REQ-025 When reset is sampled low, the block SHALL force at the next edge: state = IDLE, gnt = 0, token = one-hot bit 0, busy = 0, expire = 0, hold counter = 0.
REQ-026 Reset SHALL take priority over every other event, including a grant in progress: a mid-grant reset clears gnt at the next edge with no expire pulse.
REQ-027 The first arbitration after reset deassertion SHALL use token = 0001 (N = 4).

Verification (N=4, MAX_HOLD=4)
REQ-028 Reset: hold reset low 2 cycles with req=1111 -> gnt=0000, token=0001, busy=0, expire=0 throughout.
REQ-029 Single request: req=0100 from cycle 1 and dropped at cycle 3 -> gnt=0100 in cycles 2-3, gnt=0000 in cycle 4, token=1000 from cycle 4, expire=0.
REQ-030 Full contention: req=1111 held constantly -> grant sequence 0001, 0010, 0100, 1000, 0001, each grant 4 cycles wide, 1 idle cycle between grants, one expire pulse per grant, token stepping 0010, 0100, 1000, 0001.
REQ-031 Wrap search: token=1000 in IDLE, req=0011 -> next gnt=0001, then on release token=0010.
REQ-032 Simultaneous edge: winner drops req on the edge where the counter reaches 4 -> gnt released, expire=0; and reset low mid-grant -> gnt=0000, token=0001 at the next edge.
REQ-033 Every scenario SHALL check on every cycle that gnt and token are one-hot or zero, that token != 0, and that busy == |gnt.
